branch_predict_unit: RTL and testbench

- Successor to the single-cycle branch decision logic, parametrised in table depth, counter width and PC width.
- Holds a bimodal branch history table (BHT) of saturating counters and gives a taken/not-taken prediction to fetch.
- At execute it resolves the actual branch outcome, including unsigned compares, and flags mispredictions to the pipeline redirect logic.
- Trains the table on every resolved conditional branch.

---
 rtl/branch_predict_unit.sv | 123 ++++++++++++
 tb/tb_branch_predict_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: bimodal branch predictor with execute-stage resolution.
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_f_pc                 fetch PC -> o_f_pred_taken (MSB of indexed counter)
//   i_ex_*                 execute-stage branch/jump info and compare flags
//   o_ex_taken             actual control transfer
//   o_ex_redirect          jump, or conditional branch whose outcome differs
//                          from the carried prediction
// Optional: BRANCH_PREDICT_UNIT_STATS_EN adds o_stat_branches / o_stat_mispred.
module branch_predict_unit #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNTR_BITS   = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [PC_WIDTH-1:0] i_f_pc,
  output logic                o_f_pred_taken,
  input  logic                i_ex_valid,
  input  logic                i_ex_branch,
  input  logic                i_ex_jump,
  input  logic [2:0]          i_ex_funct3,
  input  logic                i_ex_eq,
  input  logic                i_ex_slt,
  input  logic                i_ex_sltu,
  input  logic [PC_WIDTH-1:0] i_ex_pc,
  input  logic                i_ex_pred_taken,
  output logic                o_ex_taken,
  output logic                o_ex_redirect
`ifdef BRANCH_PREDICT_UNIT_STATS_EN
  ,
  output logic [31:0]         o_stat_branches,
  output logic [31:0]         o_stat_mispred
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CNTR_BITS-1:0] CTR_RST = CNTR_BITS'((1 << (CNTR_BITS - 1)) - 1);

  logic [CNTR_BITS-1:0] bht_q [BHT_ENTRIES];
  logic [CNTR_BITS-1:0] bht_d [BHT_ENTRIES];

  logic [IDX_W-1:0]     f_idx;
  logic [IDX_W-1:0]     ex_idx;
  logic [CNTR_BITS-1:0] ex_ctr;
  logic                 cond;
  logic                 f3_ok;
  logic                 upd_en;
  logic                 unused_pc_bits;

  assign f_idx  = i_f_pc[IDX_W+1:2];
  assign ex_idx = i_ex_pc[IDX_W+1:2];
  assign ex_ctr = bht_q[ex_idx];

  // Only the index field of each PC is consumed.
  assign unused_pc_bits = ^{i_f_pc, i_ex_pc};

  assign o_f_pred_taken = bht_q[f_idx][CNTR_BITS-1];

  always_comb begin
    cond  = 1'b0;
    f3_ok = 1'b1;
    case (i_ex_funct3)
      3'b000:  cond = i_ex_eq;
      3'b001:  cond = ~i_ex_eq;
      3'b100:  cond = i_ex_slt;
      3'b101:  cond = ~i_ex_slt;
      3'b110:  cond = i_ex_sltu;
      3'b111:  cond = ~i_ex_sltu;
      default: f3_ok = 1'b0;
    endcase
  end

  assign o_ex_taken    = i_ex_valid & (i_ex_jump | (i_ex_branch & cond));
  assign o_ex_redirect = i_ex_valid & (i_ex_jump | (i_ex_branch & (cond != i_ex_pred_taken)));
  assign upd_en        = i_ex_valid & i_ex_branch & ~i_ex_jump & f3_ok;

  always_comb begin
    bht_d = bht_q;
    if (upd_en) begin
      if (cond) begin
        if (ex_ctr != '1) bht_d[ex_idx] = ex_ctr + CNTR_BITS'(1);
      end else begin
        if (ex_ctr != '0) bht_d[ex_idx] = ex_ctr - CNTR_BITS'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_RST;
    end else begin
      bht_q <= bht_d;
    end
  end

`ifdef BRANCH_PREDICT_UNIT_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (upd_en) begin
      stat_br_d = stat_br_q + 32'd1;
      if (o_ex_redirect) stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign o_stat_branches = stat_br_q;
  assign o_stat_mispred  = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit (default parameters: 64 x 2-bit, 32-bit PC).
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_pc;
  logic        f_pred;
  logic        ex_valid, ex_branch, ex_jump;
  logic [2:0]  ex_f3;
  logic        ex_eq, ex_slt, ex_sltu;
  logic [31:0] ex_pc;
  logic        ex_pred;
  logic        ex_taken, ex_redir;
`ifdef BRANCH_PREDICT_UNIT_STATS_EN
  logic [31:0] st_br, st_mp;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(
    .PC_WIDTH   (32),
    .BHT_ENTRIES(64),
    .CNTR_BITS  (2)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_f_pc         (f_pc),
    .o_f_pred_taken (f_pred),
    .i_ex_valid     (ex_valid),
    .i_ex_branch    (ex_branch),
    .i_ex_jump      (ex_jump),
    .i_ex_funct3    (ex_f3),
    .i_ex_eq        (ex_eq),
    .i_ex_slt       (ex_slt),
    .i_ex_sltu      (ex_sltu),
    .i_ex_pc        (ex_pc),
    .i_ex_pred_taken(ex_pred),
    .o_ex_taken     (ex_taken),
    .o_ex_redirect  (ex_redir)
`ifdef BRANCH_PREDICT_UNIT_STATS_EN
    ,
    .o_stat_branches(st_br),
    .o_stat_mispred (st_mp)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_f3 = 3'b000;
    ex_eq = 0; ex_slt = 0; ex_sltu = 0; ex_pc = '0; ex_pred = 0;
  endtask

  task automatic ex_br(input logic [31:0] pc, input logic [2:0] f3,
                       input logic eq, input logic slt, input logic sltu, input logic pred);
    ex_valid = 1; ex_branch = 1; ex_jump = 0; ex_f3 = f3;
    ex_eq = eq; ex_slt = slt; ex_sltu = sltu; ex_pc = pc; ex_pred = pred;
  endtask

  task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
    f_pc = pc;
    #1;
    chk(tag, {31'd0, f_pred}, {31'd0, exp});
  endtask

  initial begin
    rst = 1; f_pc = '0;
    ex_idle();
    step();
    rst = 0;

    // Reset state: every counter weakly not-taken.
    for (int unsigned a = 0; a < 'h100; a += 4) pred_at("reset_sweep", a, 1'b0);

    // Counter at index 0 is 1: one taken update lifts it to 2 (predict taken).
    ex_br(32'h0, 3'b000, 1, 0, 0, 0);
    step();
    ex_idle();
    pred_at("rst_val_is_1", 32'h0, 1'b1);
    ex_br(32'h0, 3'b000, 0, 0, 0, 1);
    step();
    ex_idle();
    pred_at("idx0_restored", 32'h0, 1'b0);

    // BEQ taken at 0x40, predicted not-taken, twice.
    ex_br(32'h40, 3'b000, 1, 0, 0, 0);
    f_pc = 32'h40;
    #1;
    chk("beq1_taken", ex_taken, 1);
    chk("beq1_redir", ex_redir, 1);
    chk("beq1_pred",  f_pred,   0);
    step();
    chk("beq2_redir", ex_redir, 1);
    chk("beq2_pred",  f_pred,   1);
    step();
    step();                                   // third taken update: saturates at 3
    // Correct prediction never redirects.
    ex_pred = 1;
    #1;
    chk("beq_ok_redir", ex_redir, 0);
    // Two not-taken updates: 3 -> 2 -> 1 only if it saturated.
    ex_br(32'h40, 3'b000, 0, 0, 0, 1);
    #1;
    chk("beq_nt_taken", ex_taken, 0);
    chk("beq_nt_redir", ex_redir, 1);
    step();
    chk("sat_dec1", f_pred, 1);
    step();
    chk("sat_dec2", f_pred, 0);
    ex_idle();

    // Condition decode (combinational only).
    ex_br(32'h0C0, 3'b110, 0, 1, 0, 0); #1; chk("bltu_taken", ex_taken, 0);
    ex_f3 = 3'b111;                     #1; chk("bgeu_taken", ex_taken, 1);
    ex_br(32'h0C0, 3'b101, 1, 0, 0, 0); #1; chk("bge_taken",  ex_taken, 1);
    ex_br(32'h0C0, 3'b100, 0, 1, 0, 1); #1; chk("blt_taken",  ex_taken, 1);
    ex_br(32'h0C0, 3'b001, 0, 0, 0, 0); #1; chk("bne_taken",  ex_taken, 1);
    chk("bne_redir", ex_redir, 1);
    ex_br(32'h0C0, 3'b010, 1, 1, 1, 1); #1; chk("f3_010_taken", ex_taken, 0);
    chk("f3_010_redir", ex_redir, 1);
    ex_f3 = 3'b011;                     #1; chk("f3_011_taken", ex_taken, 0);
    ex_idle();

    // Invalid funct3 at 0xC4 must not decrement: afterwards one taken step gives 2.
    ex_br(32'h0C4, 3'b010, 0, 0, 0, 0);
    step();
    step();
    ex_br(32'h0C4, 3'b000, 1, 0, 0, 0);
    step();
    ex_idle();
    pred_at("f3_no_update", 32'h0C4, 1'b1);

    // JAL at 0x80.
    ex_idle();
    ex_valid = 1; ex_jump = 1; ex_pc = 32'h80; ex_pred = 1;
    #1;
    chk("jal_taken", ex_taken, 1);
    chk("jal_redir", ex_redir, 1);
    // Jump + branch with cond=0: jump wins; must not train (would increment if it did).
    ex_branch = 1; ex_f3 = 3'b000; ex_eq = 1;
    #1;
    ex_eq = 0;
    #1;
    chk("jmpbr_taken", ex_taken, 1);
    ex_eq = 1;
    step();
    step();
    ex_idle();
    pred_at("jal_no_update", 32'h80, 1'b0);

    // Invalid slot.
    ex_br(32'h80, 3'b000, 1, 0, 0, 0);
    ex_valid = 0; ex_jump = 1;
    #1;
    chk("inv_jal_taken", ex_taken, 0);
    chk("inv_jal_redir", ex_redir, 0);
    ex_jump = 0;
    #1;
    chk("inv_br_taken", ex_taken, 0);
    chk("inv_br_redir", ex_redir, 0);
    step();
    step();
    ex_idle();
    pred_at("inv_no_update", 32'h80, 1'b0);

    // Same-cycle read/write at 0x100 (aliases index 0, counter 1).
    ex_br(32'h100, 3'b000, 1, 0, 0, 0);
    f_pc = 32'h100;
    #1;
    chk("rw_same_cycle", f_pred, 0);
    step();
    ex_idle();
    #1;
    chk("rw_next_cycle", f_pred, 1);

    // Reset beats a pending update at a trained index.
    ex_br(32'h40, 3'b000, 1, 0, 0, 0);
    step();
    step();                                   // 0x40: 1 -> 2 -> 3
    rst = 1;
    step();
    rst = 0;
    ex_idle();
    pred_at("rst_over_upd", 32'h40, 1'b0);
    pred_at("rst_idx0",     32'h0,  1'b0);
`ifdef BRANCH_PREDICT_UNIT_STATS_EN
    chk("stat_br_rst", st_br, 32'd0);
    chk("stat_mp_rst", st_mp, 32'd0);
`endif
    ex_br(32'h40, 3'b000, 1, 0, 0, 0);       // mispredicted
    step();
    ex_pred = 1;                              // correctly predicted
    step();
    ex_idle();
`ifdef BRANCH_PREDICT_UNIT_STATS_EN
    chk("stat_br_cnt", st_br, 32'd2);
    chk("stat_mp_cnt", st_mp, 32'd1);
`endif
    // 1 -> 2 -> 3 after reset; a single decrement must still predict taken.
    ex_br(32'h40, 3'b000, 0, 0, 0, 1);
    step();
    ex_idle();
    pred_at("post_rst_train", 32'h40, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
